// File: rtl/decrypt_function_1.sv
// rtl/decrypt_function_1.sv - two-stage decryptor: rebuilds the key mask and subtracts it from the cipher field
//
// Purpose:
//   Splits a 78-bit encrypted word into cipher field x[60:0], key r[10:0]
//   and tag[5:0]. It rebuilds the 60-bit mask b from r and returns
//   d = x - b as the recovered data. A word is marked malformed when the
//   subtraction borrows or when the difference does not fit in 60 bits.
//   Malformed words are still delivered, never dropped.
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   in_valid   upstream word present on in_enc
//   in_ready   block accepts a word this cycle (combinational from out_ready)
//   in_enc     {x[77:17], r[16:6], tag[5:0]}
//   out_valid  result present on out_*
//   out_ready  downstream accepts the result
//   out_data   recovered 60-bit data
//   out_key    recovered key r
//   out_tag    tag, passed through unchanged
//   out_err    result is malformed
//   err_count  saturating count of delivered malformed results

module decrypt_function_1 #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [77:0]          in_enc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [59:0]          out_data,
    output logic [10:0]          out_key,
    output logic [5:0]           out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // The mask interleaves r and ~r in 11-bit lanes; the top lane is
    // only 5 bits wide, so it carries r[4:0].
    function automatic logic [59:0] build_mask(input logic [10:0] r);
        logic [59:0] b;
        b        = '0;
        b[10:0]  = r;
        b[21:11] = ~r;
        b[32:22] = ~r;
        b[43:33] = r;
        b[54:44] = ~r;
        b[59:55] = r[4:0];
        return b;
    endfunction

    // Input field split
    logic [60:0] in_x;
    logic [10:0] in_r;
    logic [5:0]  in_tag;

    assign in_x   = in_enc[77:17];
    assign in_r   = in_enc[16:6];
    assign in_tag = in_enc[5:0];

    // Stage 1 registers
    logic        s1_valid;
    logic [60:0] s1_x;
    logic [10:0] s1_r;
    logic [5:0]  s1_tag;
    logic [59:0] s1_b;

    // Stage 2 valid; the S2 data registers are the out_* ports themselves
    logic        s2_valid;

    // Pipeline control
    logic        s2_adv;
    logic        s1_adv;
    logic        accept;
    logic        deliver;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid && in_ready;
    assign deliver   = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Subtraction with one extra bit so the borrow out of 61 bits is visible:
    // diff[61] is the borrow (x < b), diff[60] set means d overflows 60 bits.
    logic [61:0] diff;
    logic        diff_err;

    assign diff     = {1'b0, s1_x} - {2'b00, s1_b};
    assign diff_err = diff[61] | diff[60];

    // Stage 1: the payload is only loaded on an accept, so a stalled
    // stage keeps its contents even if upstream changes in_enc.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_r     <= '0;
            s1_tag   <= '0;
            s1_b     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_x   <= in_x;
                s1_r   <= in_r;
                s1_tag <= in_tag;
                s1_b   <= build_mask(in_r);
            end
        end
    end

    // Stage 2: outputs only change when S2 advances with fresh data,
    // which keeps them stable during a downstream stall.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_key  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= diff[59:0];
                    out_key  <= s1_r;
                    out_tag  <= s1_tag;
                    out_err  <= diff_err;
                end
            end
        end
    end

    // Error counter: counts delivered malformed results, sticks at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_count <= '0;
        end else if (deliver && out_err && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decrypt_function_1.sv
// tb/tb_decrypt_function_1.sv - scoreboard bench for decrypt_function_1

module tb_decrypt_function_1;

    typedef struct packed {
        logic [59:0] data;
        logic [10:0] key;
        logic [5:0]  tag;
        logic        err;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [77:0] in_enc;
    logic        out_valid;
    logic        out_ready;
    logic [59:0] out_data;
    logic [10:0] out_key;
    logic [5:0]  out_tag;
    logic        out_err;
    logic [15:0] err_count;

    // Second instance with a 2-bit counter, same stimulus
    logic        in_ready2;
    logic        out_valid2;
    logic [59:0] out_data2;
    logic [10:0] out_key2;
    logic [5:0]  out_tag2;
    logic        out_err2;
    logic [1:0]  err_count2;

    decrypt_function_1 #(.ERR_CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_enc(in_enc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_key(out_key), .out_tag(out_tag),
        .out_err(out_err), .err_count(err_count)
    );

    decrypt_function_1 #(.ERR_CNT_W(2)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_enc(in_enc),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_key(out_key2), .out_tag(out_tag2),
        .out_err(out_err2), .err_count(err_count2)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    bit   bp_mode  = 1'b0;
    int   max_run  = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [59:0] mask_of(input logic [10:0] r);
        return {r[4:0], ~r, r, ~r, ~r, r};
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one word and hold it until accepted; the expected result is
    // queued at the negedge before the accepting edge.
    task automatic send(input logic [60:0] x, input logic [10:0] r,
                        input logic [5:0] tag, input exp_t e, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_enc   = {x, r, tag};
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end else begin
                stalls++;
            end
            tick();
        end
        if (!done) check(1'b0, "accept_timeout", 64'(stalls), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(output int stalls);
        logic [63:0] t;
        logic [10:0] r;
        logic [59:0] data;
        logic [60:0] x;
        exp_t        e;
        t    = {$urandom(), $urandom()};
        data = t[59:0];
        r    = 11'($urandom_range(0, 2047));
        x    = {1'b0, data} + {1'b0, mask_of(r)};
        e    = '{data: data, key: r, tag: 6'($urandom_range(0, 63)), err: 1'b0};
        send(x, r, e.tag, e, stalls);
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) check(1'b0, "drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Monitor / scoreboard
    int          cnt_m  = 0;
    int          cnt2_m = 0;
    int          run    = 0;
    bit          held   = 1'b0;
    logic [59:0] h_data;
    logic [10:0] h_key;
    logic [5:0]  h_tag;
    logic        h_err;

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
            run    = 0;
            held   = 1'b0;
        end else begin
            if (held) begin
                check(out_valid && out_data == h_data && out_key == h_key &&
                      out_tag == h_tag && out_err == h_err, "stall_stable",
                      64'(out_data), 64'(h_data));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_output", 64'(out_data), 64'd0);
                end else begin
                    e = q.pop_front();
                    check(out_data == e.data, "out_data", 64'(out_data), 64'(e.data));
                    check(out_key  == e.key,  "out_key",  64'(out_key),  64'(e.key));
                    check(out_tag  == e.tag,  "out_tag",  64'(out_tag),  64'(e.tag));
                    check(out_err  == e.err,  "out_err",  64'(out_err),  64'(e.err));
                    check(out_valid2 && out_data2 == e.data && out_key2 == e.key &&
                          out_tag2 == e.tag && out_err2 == e.err, "dut2_result",
                          64'(out_data2), 64'(e.data));
                    check(err_count == 16'(cnt_m), "err_count", 64'(err_count), 64'(cnt_m));
                    check(err_count2 == 2'(cnt2_m), "err_count_sat", 64'(err_count2), 64'(cnt2_m));
                    if (e.err) begin
                        cnt_m  = cnt_m + 1;
                        cnt2_m = (cnt2_m < 3) ? cnt2_m + 1 : 3;
                    end
                end
                run = run + 1;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            held   = out_valid && !out_ready;
            h_data = out_data;
            h_key  = out_key;
            h_tag  = out_tag;
            h_err  = out_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        exp_t e;
        Rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_enc    = '0;
        out_ready = 1'b1;
        #2;
        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(in_ready == 1'b1,  "rst_in_ready",  64'(in_ready),  64'd1);
        check(out_data == '0 && out_key == '0 && out_tag == '0 && out_err == 1'b0,
              "rst_outputs", 64'(out_data), 64'd0);
        check(err_count == '0 && err_count2 == '0, "rst_err_count", 64'(err_count), 64'd0);
        tick(); tick(); tick();
        Rst_n = 1'b1;

        // Zero data, zero key: x equals the r=0 mask
        e = '{data: 60'h0, key: 11'h0, tag: 6'h2A, err: 1'b0};
        send(61'h007F_F001_FFFF_F800, 11'h0, 6'h2A, e, st);
        check(out_valid == 1'b0, "latency_s1", 64'(out_valid), 64'd0);
        tick();
        check(out_valid == 1'b1, "latency_s2", 64'(out_valid), 64'd1);

        // All-ones data, all-ones key: x = 60'hFFF..F + 60'hF80_0FFE_0000_07FF
        e = '{data: 60'hFFF_FFFF_FFFF_FFFF, key: 11'h7FF, tag: 6'h15, err: 1'b0};
        send(61'h1F80_0FFE_0000_07FE, 11'h7FF, 6'h15, e, st);
        wait_empty();

        // Malformed: borrow, then 61-bit overflow
        e = '{data: 60'hF80_0FFE_0000_0800, key: 11'h0, tag: 6'h01, err: 1'b1};
        send(61'h0, 11'h0, 6'h01, e, st);
        wait_empty();
        check(err_count == 16'd1, "err_count_first", 64'(err_count), 64'd1);
        e = '{data: 60'hF80_0FFE_0000_07FF, key: 11'h0, tag: 6'h02, err: 1'b1};
        send(61'h1FFF_FFFF_FFFF_FFFF, 11'h0, 6'h02, e, st);
        wait_empty();
        check(err_count == 16'd2, "err_count_second", 64'(err_count), 64'd2);

        // Backpressure with pseudo-random out_ready
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) send_rand(st);
        wait_empty();
        bp_mode   = 1'b0;

        // Full pipeline: two accepts with out_ready low stop the input
        out_ready = 1'b0;
        send_rand(st);
        send_rand(st);
        @(negedge Clk);
        check(in_ready == 1'b0 && in_ready2 == 1'b0, "full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check(in_ready == 1'b1 && in_ready2 == 1'b1, "release_in_ready", 64'(in_ready), 64'd1);
        tick();
        wait_empty();

        // Full throughput: no stalls and 100 consecutive deliveries
        for (int i = 0; i < 100; i++) begin
            send_rand(st);
            check(st == 0, "tput_in_ready", 64'(st), 64'd0);
        end
        wait_empty();
        check(max_run >= 100, "tput_run", 64'(max_run), 64'd100);

        // Reset with two words in flight
        out_ready = 1'b0;
        send_rand(st);
        send_rand(st);
        Rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        check(err_count == '0 && err_count2 == '0, "midrst_err_count", 64'(err_count), 64'd0);
        check(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
        tick(); tick();
        Rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick();
        check(out_valid == 1'b0, "postrst_idle", 64'(out_valid), 64'd0);

        // Five malformed words: 16-bit counter reaches 5, 2-bit one sticks at 3
        for (int i = 0; i < 5; i++) begin
            e = '{data: 60'hF80_0FFE_0000_0800, key: 11'h0, tag: 6'(i + 8), err: 1'b1};
            send(61'h0, 11'h0, 6'(i + 8), e, st);
        end
        wait_empty();
        check(err_count == 16'd5, "err_count_five", 64'(err_count), 64'd5);
        check(err_count2 == 2'd3, "err_count_saturated", 64'(err_count2), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
